instr_fetch_unit: RTL and testbench

- Instruction-fetch initiator that drives the synchronous instruction ROM.
- The ROM samples its address on the clock edge and returns the word one cycle later.
- Tracks that one-cycle latency, tags each returned word with its PC, and holds the word under back-pressure with a 1-entry hold buffer.
- Redirects on branches and context switches (e.g. jump to the OS region at 200) and flags out-of-range fetches. Sits between the ROM and the decode stage.

---
 rtl/instr_fetch_unit.sv | 95 +++++++++
 tb/tb_instr_fetch_unit.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch initiator for a synchronous ROM: one-cycle read latency tracking,
// PC tagging, a 1-entry hold buffer under decode stall, redirect and out-of-range fault.
module instr_fetch_unit #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ROM_SIZE   = 800,
  parameter int unsigned RESET_PC   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_q,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  output logic                  fetch_fault
);

  localparam logic [ADDR_WIDTH-1:0] ROM_LIMIT = ADDR_WIDTH'(ROM_SIZE);
  localparam logic [ADDR_WIDTH-1:0] PC_RESET  = ADDR_WIDTH'(RESET_PC);

  logic [ADDR_WIDTH-1:0] pc_q;
  logic                  inflight_v;
  logic [ADDR_WIDTH-1:0] inflight_pc;
  logic                  hold_v;
  logic [DATA_WIDTH-1:0] hold_instr;
  logic [ADDR_WIDTH-1:0] hold_pc;
  logic                  fault_q;

  logic want_fetch;
  logic in_range;
  logic issue;
  logic fault_set;

  assign want_fetch = enable && !stall && !redirect_valid;
  assign in_range   = (pc_q < ROM_LIMIT);
  assign issue      = want_fetch && !fault_q && in_range;
  assign fault_set  = want_fetch && !in_range;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= PC_RESET;
      inflight_v  <= 1'b0;
      inflight_pc <= '0;
      hold_v      <= 1'b0;
      hold_instr  <= '0;
      hold_pc     <= '0;
      fault_q     <= 1'b0;
    end else if (redirect_valid) begin
      pc_q       <= redirect_pc;
      inflight_v <= 1'b0;
      hold_v     <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      if (fault_set)
        fault_q <= 1'b1;
      // The ROM word only exists for one cycle; a stalled one is parked in the hold buffer.
      if (issue) begin
        inflight_v  <= 1'b1;
        inflight_pc <= pc_q;
        pc_q        <= pc_q + ADDR_WIDTH'(1);
      end else if (stall && inflight_v) begin
        hold_v     <= 1'b1;
        hold_instr <= rom_q;
        hold_pc    <= inflight_pc;
        inflight_v <= 1'b0;
      end else begin
        inflight_v <= 1'b0;
      end
      if (hold_v && !stall)
        hold_v <= 1'b0;
    end
  end

  always_comb begin
    instr    = '0;
    instr_pc = '0;
    if (hold_v) begin
      instr    = hold_instr;
      instr_pc = hold_pc;
    end else if (inflight_v) begin
      instr    = rom_q;
      instr_pc = inflight_pc;
    end
  end

  assign instr_valid = hold_v | inflight_v;
  assign fetch_fault = fault_q;
  assign rom_addr    = pc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus randomized traffic checked
// against a single-slot delivery model of the fetch stream.
module tb_instr_fetch_unit;

  localparam int unsigned RS = 800;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] rom_addr;
  logic [31:0] rom_q;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        fetch_fault;

  int n_pass;
  int n_total;

  instr_fetch_unit #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .ROM_SIZE  (800),
    .RESET_PC  (0)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .rom_addr      (rom_addr),
    .rom_q         (rom_q),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .fetch_fault   (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM: ROM[i] = i + 0x100, out-of-range reads return a marker.
  always @(posedge clk)
    rom_q <= (rom_addr < 32'd800) ? rom_addr + 32'h100 : 32'hBAD0_0000;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    tick(); tick();
    n_total++;
    if (instr_valid !== 1'b0 || fetch_fault !== 1'b0)
      $display("FAIL reset_flags: valid=%0b fault=%0b want 0 0", instr_valid, fetch_fault);
    else n_pass++;
    n_total++;
    if (rom_addr !== 32'd0 || instr !== 32'd0 || instr_pc !== 32'd0)
      $display("FAIL reset_data: rom_addr=%0d instr=%h pc=%0d want 0 0 0", rom_addr, instr, instr_pc);
    else n_pass++;
  endtask

  task automatic test_stream();
    enable = 1'b1;
    rst_n  = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      n_total++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'(k) || instr !== 32'(k) + 32'h100)
        $display("FAIL stream[%0d]: valid=%0b pc=%0d instr=%h want 1 %0d %h",
                 k, instr_valid, instr_pc, instr, k, 32'(k) + 32'h100);
      else n_pass++;
    end
  endtask

  task automatic test_stall();
    redirect_valid = 1'b1; redirect_pc = 32'd5;
    tick();
    redirect_valid = 1'b0;
    n_total++;
    if (instr_valid !== 1'b0) $display("FAIL stall_bubble: valid=%0b want 0", instr_valid);
    else n_pass++;
    tick();
    stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      n_total++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'd5 || instr !== 32'h105)
        $display("FAIL stall_hold[%0d]: valid=%0b pc=%0d instr=%h want 1 5 105", k, instr_valid, instr_pc, instr);
      else n_pass++;
    end
    stall = 1'b0;
    for (int k = 6; k < 8; k++) begin
      tick();
      n_total++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'(k) || instr !== 32'(k) + 32'h100)
        $display("FAIL stall_resume[%0d]: valid=%0b pc=%0d instr=%h want 1 %0d", k, instr_valid, instr_pc, instr, k);
      else n_pass++;
    end
  endtask

  task automatic test_redirect();
    redirect_valid = 1'b1; redirect_pc = 32'd8;
    tick();
    redirect_valid = 1'b0;
    tick(); tick(); tick();
    n_total++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'd10)
      $display("FAIL redir_pre: valid=%0b pc=%0d want 1 10", instr_valid, instr_pc);
    else n_pass++;
    redirect_valid = 1'b1; redirect_pc = 32'd200;
    tick();
    redirect_valid = 1'b0;
    n_total++;
    if (instr_valid !== 1'b0) $display("FAIL redir_gap: valid=%0b want 0", instr_valid);
    else n_pass++;
    for (int k = 200; k < 203; k++) begin
      tick();
      n_total++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'(k) || instr !== 32'(k) + 32'h100)
        $display("FAIL redir_stream[%0d]: valid=%0b pc=%0d instr=%h want 1 %0d", k, instr_valid, instr_pc, instr, k);
      else n_pass++;
    end
  endtask

  task automatic test_redirect_hold();
    redirect_valid = 1'b1; redirect_pc = 32'd30;
    tick();
    redirect_valid = 1'b0;
    tick();
    stall = 1'b1;
    tick();
    n_total++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'd30 || instr !== 32'h11e)
      $display("FAIL rhold_held: valid=%0b pc=%0d instr=%h want 1 30 11e", instr_valid, instr_pc, instr);
    else n_pass++;
    redirect_valid = 1'b1; redirect_pc = 32'd400;
    tick();
    redirect_valid = 1'b0; stall = 1'b0;
    n_total++;
    if (instr_valid !== 1'b0 || instr !== 32'd0 || instr_pc !== 32'd0)
      $display("FAIL rhold_flush: valid=%0b pc=%0d instr=%h want 0 0 0", instr_valid, instr_pc, instr);
    else n_pass++;
    for (int k = 400; k < 402; k++) begin
      tick();
      n_total++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'(k) || instr !== 32'(k) + 32'h100)
        $display("FAIL rhold_new[%0d]: valid=%0b pc=%0d instr=%h want 1 %0d", k, instr_valid, instr_pc, instr, k);
      else n_pass++;
    end
  endtask

  task automatic test_enable();
    redirect_valid = 1'b1; redirect_pc = 32'd100;
    tick();
    redirect_valid = 1'b0;
    tick();
    enable = 1'b0; stall = 1'b1;
    tick();
    n_total++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'd100)
      $display("FAIL en_held: valid=%0b pc=%0d want 1 100", instr_valid, instr_pc);
    else n_pass++;
    stall = 1'b0;
    tick();
    n_total++;
    if (instr_valid !== 1'b0 || rom_addr !== 32'd101)
      $display("FAIL en_idle: valid=%0b rom_addr=%0d want 0 101", instr_valid, rom_addr);
    else n_pass++;
    enable = 1'b1;
    tick();
    n_total++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'd101 || instr !== 32'h165)
      $display("FAIL en_resume: valid=%0b pc=%0d instr=%h want 1 101 165", instr_valid, instr_pc, instr);
    else n_pass++;
  endtask

  task automatic test_fault();
    redirect_valid = 1'b1; redirect_pc = 32'd798;
    tick();
    redirect_valid = 1'b0;
    for (int k = 798; k < 800; k++) begin
      tick();
      n_total++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'(k) || fetch_fault !== 1'b0)
        $display("FAIL fault_tail[%0d]: valid=%0b pc=%0d fault=%0b want 1 %0d 0", k, instr_valid, instr_pc, fetch_fault, k);
      else n_pass++;
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_total++;
      if (instr_valid !== 1'b0 || fetch_fault !== 1'b1 || rom_addr !== 32'd800)
        $display("FAIL fault_sticky[%0d]: valid=%0b fault=%0b rom_addr=%0d want 0 1 800", k, instr_valid, fetch_fault, rom_addr);
      else n_pass++;
    end
    redirect_valid = 1'b1; redirect_pc = 32'd0;
    tick();
    redirect_valid = 1'b0;
    n_total++;
    if (fetch_fault !== 1'b0 || instr_valid !== 1'b0)
      $display("FAIL fault_clear: fault=%0b valid=%0b want 0 0", fetch_fault, instr_valid);
    else n_pass++;
    tick();
    n_total++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'd0 || instr !== 32'h100)
      $display("FAIL fault_resume: valid=%0b pc=%0d instr=%h want 1 0 100", instr_valid, instr_pc, instr);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    redirect_valid = 1'b1; redirect_pc = 32'd50;
    tick();
    redirect_valid = 1'b0;
    tick();
    n_total++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'd50)
      $display("FAIL areset_pre: valid=%0b pc=%0d want 1 50", instr_valid, instr_pc);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (instr_valid !== 1'b0 || instr !== 32'd0 || instr_pc !== 32'd0 || rom_addr !== 32'd0)
      $display("FAIL areset_now: valid=%0b instr=%h pc=%0d rom_addr=%0d want 0 0 0 0", instr_valid, instr, instr_pc, rom_addr);
    else n_pass++;
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_total++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'd0 || instr !== 32'h100)
      $display("FAIL areset_restart: valid=%0b pc=%0d instr=%h want 1 0 100", instr_valid, instr_pc, instr);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] m_next;
    logic [31:0] m_pc;
    logic        m_have;
    logic        m_fault;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    rst_n = 1'b0; enable = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
    #2;
    rst_n = 1'b1;
    m_next = 32'd0; m_pc = 32'd0; m_have = 1'b0; m_fault = 1'b0;
    for (int i = 0; i < 600; i++) begin
      enable         = ($urandom_range(0, 9) != 0);
      stall          = ($urandom_range(0, 3) == 0);
      redirect_valid = ($urandom_range(0, 24) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(790, 805))
                                                   : 32'($urandom_range(0, 799));
      // One presented-word slot: it leaves when decode takes it, a new fetch refills it.
      if (redirect_valid) begin
        m_next = redirect_pc; m_have = 1'b0; m_fault = 1'b0;
      end else begin
        if (m_have && !stall) m_have = 1'b0;
        if (enable && !stall) begin
          if (!m_fault && m_next < RS) begin
            m_have = 1'b1; m_pc = m_next; m_next = m_next + 32'd1;
          end else if (m_next >= RS) begin
            m_fault = 1'b1;
          end
        end
      end
      e_pc    = m_have ? m_pc : 32'd0;
      e_instr = m_have ? m_pc + 32'h100 : 32'd0;
      tick();
      n_total++;
      if (instr_valid !== m_have || instr_pc !== e_pc || instr !== e_instr)
        $display("FAIL rand_out[%0d]: valid=%0b pc=%0d instr=%h want %0b %0d %h",
                 i, instr_valid, instr_pc, instr, m_have, e_pc, e_instr);
      else n_pass++;
      n_total++;
      if (fetch_fault !== m_fault || rom_addr !== m_next)
        $display("FAIL rand_ctl[%0d]: fault=%0b rom_addr=%0d want %0b %0d", i, fetch_fault, rom_addr, m_fault, m_next);
      else n_pass++;
      n_total++;
      if ((dut.hold_v & dut.inflight_v) !== 1'b0)
        $display("FAIL rand_excl[%0d]: hold_v=%0b inflight_v=%0b want not both", i, dut.hold_v, dut.inflight_v);
      else n_pass++;
    end
    redirect_valid = 1'b0; stall = 1'b0;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_hold();
    test_enable();
    test_fault();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
